// File: rtl/game_stacker_param_if.sv
// Player-facing bus of the stacker engine: button/select inputs and the
// display, score and status outputs shared with the game fabric.
interface game_stacker_param_if #(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8
);
  logic [2:0]           buttons;
  logic [15:0]          userid;
  logic [1:0]           gamestate;
  logic                 game_eog;
  logic [7:0]           timer_reconfig_fb;
  logic [COLS*ROWS-1:0] game_display;
  logic [31:0]          game_data;

  modport master (
    output buttons, userid, gamestate,
    input  game_eog, timer_reconfig_fb, game_display, game_data
  );

  modport slave (
    input  buttons, userid, gamestate,
    output game_eog, timer_reconfig_fb, game_display, game_data
  );
endinterface

// File: rtl/game_stacker_param.sv
// Parametrised stacker game: a block sweeps across the current row, the player
// drops it, and only columns overlapping the row below survive.
module game_stacker_param #(
  parameter int unsigned COLS        = 8,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned INIT_LEN    = 3,
  parameter logic [1:0]  PLAY_CODE   = 2'd1,
  parameter int unsigned PERIOD_INIT = 16,
  parameter int unsigned PERIOD_STEP = 2,
  parameter int unsigned PERIOD_MIN  = 4,
  parameter int unsigned WIN_BONUS   = 10
) (
  input  logic clk,
  input  logic rst,
  game_stacker_param_if.slave bus
);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned LW = $clog2(COLS + 1);
  localparam int unsigned PW = $clog2(COLS);
  localparam int unsigned TW = 16;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MOVE, S_DROP, S_END} state_e;

  state_e                     state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]  rows_q, rows_d;
  logic [15:0]                score_q, score_d;
  logic [7:0]                 level_q, level_d;
  logic [TW-1:0]              period_q, period_d;
  logic [TW-1:0]              cnt_q, cnt_d;
  logic [RW-1:0]              cur_row_q, cur_row_d;
  logic [LW-1:0]              cur_len_q, cur_len_d;
  logic [PW-1:0]              pos_q, pos_d;
  logic                       dir_up_q, dir_up_d;
  logic                       eog_q, eog_d;
  logic [2:0]                 btn_q;

  logic                       drop_edge_c, restart_edge_c, playing_c;
  logic [31:0]                ones_c;
  logic [COLS-1:0]            block_c, kept_c;
  logic [ROWS-1:0][COLS-1:0]  disp_c;
  logic                       unused_btn_c;

  function automatic logic [LW-1:0] popcnt(input logic [COLS-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(COLS); i++) n = n + LW'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Step period for a level, floored at PERIOD_MIN without unsigned wrap.
  function automatic logic [TW-1:0] period_for(input logic [7:0] lvl);
    int unsigned red;
    red = 32'(lvl) * PERIOD_STEP;
    if (red >= PERIOD_INIT || (PERIOD_INIT - red) < PERIOD_MIN) return TW'(PERIOD_MIN);
    return TW'(PERIOD_INIT - red);
  endfunction

  assign drop_edge_c    = bus.buttons[0] & ~btn_q[0];
  assign restart_edge_c = bus.buttons[1] & ~btn_q[1];
  assign playing_c      = (bus.gamestate == PLAY_CODE);
  assign unused_btn_c   = btn_q[2];

  assign ones_c  = (32'd1 << cur_len_q) - 32'd1;
  assign block_c = COLS'(ones_c << pos_q);
  assign kept_c  = (cur_row_q == '0) ? block_c
                                     : (block_c & rows_q[RW'(cur_row_q - RW'(1))]);

  // Moving block is overlaid only while it is live.
  always_comb begin
    disp_c = rows_q;
    if (state_q == S_MOVE) disp_c[cur_row_q] = rows_q[cur_row_q] | block_c;
  end

  assign bus.game_display      = disp_c;
  assign bus.game_data         = {bus.userid, score_q};
  assign bus.game_eog          = eog_q;
  assign bus.timer_reconfig_fb = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      score_q   <= '0;
      level_q   <= '0;
      period_q  <= TW'(PERIOD_INIT);
      cnt_q     <= '0;
      cur_row_q <= '0;
      cur_len_q <= LW'(INIT_LEN);
      pos_q     <= '0;
      dir_up_q  <= 1'b1;
      eog_q     <= 1'b0;
      btn_q     <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      score_q   <= score_d;
      level_q   <= level_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      cur_row_q <= cur_row_d;
      cur_len_q <= cur_len_d;
      pos_q     <= pos_d;
      dir_up_q  <= dir_up_d;
      eog_q     <= eog_d;
      btn_q     <= bus.buttons;
    end
  end

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    score_d   = score_q;
    level_d   = level_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    cur_row_d = cur_row_q;
    cur_len_d = cur_len_q;
    pos_d     = pos_q;
    dir_up_d  = dir_up_q;
    eog_d     = eog_q;

    unique case (state_q)
      S_IDLE: begin
        eog_d = 1'b0;
        if (playing_c) state_d = S_INIT;
      end
      S_INIT: begin
        rows_d    = '0;
        score_d   = '0;
        level_d   = '0;
        period_d  = TW'(PERIOD_INIT);
        cur_row_d = '0;
        cur_len_d = LW'(INIT_LEN);
        pos_d     = '0;
        dir_up_d  = 1'b1;
        cnt_d     = '0;
        eog_d     = 1'b0;
        state_d   = S_MOVE;
      end
      S_MOVE: begin
        if (!playing_c) begin
          eog_d   = 1'b0;
          state_d = S_IDLE;
        end else if (drop_edge_c) begin
          state_d = S_DROP;
        end else if (cnt_q == period_q - TW'(1)) begin
          cnt_d = '0;
          // A full-width block has nowhere to go.
          if (32'(cur_len_q) != COLS) begin
            if (dir_up_q) begin
              if (32'(pos_q) == COLS - 32'(cur_len_q)) begin
                dir_up_d = 1'b0;
                pos_d    = pos_q - PW'(1);
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else if (pos_q == '0) begin
              dir_up_d = 1'b1;
              pos_d    = pos_q + PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DROP: begin
        if (!playing_c) begin
          eog_d   = 1'b0;
          state_d = S_IDLE;
        end else if (kept_c == '0) begin
          eog_d   = 1'b1;
          state_d = S_END;
        end else begin
          rows_d[cur_row_q] = kept_c;
          score_d = sat_add(score_q, 16'(popcnt(kept_c)));
          if (32'(cur_row_q) == ROWS - 1) begin
            score_d = sat_add(sat_add(score_q, 16'(popcnt(kept_c))), 16'(WIN_BONUS));
            eog_d   = 1'b1;
            state_d = S_END;
          end else begin
            cur_row_d = cur_row_q + RW'(1);
            cur_len_d = popcnt(kept_c);
            pos_d     = '0;
            dir_up_d  = 1'b1;
            cnt_d     = '0;
            level_d   = (level_q == 8'hFF) ? level_q : level_q + 8'd1;
            period_d  = period_for(level_d);
            state_d   = S_MOVE;
          end
        end
      end
      S_END: begin
        eog_d = 1'b1;
        if (!playing_c) begin
          eog_d   = 1'b0;
          state_d = S_IDLE;
        end else if (restart_edge_c) begin
          state_d = S_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
